// File: rtl/mapper_pkg.sv
// mapper_pkg
//   Shared types for the cartridge CPU write path: bus widths, the captured
//   write beat (addr/data) and the capture FSM state encoding.
package mapper_pkg;

    localparam int CPU_AW = 15;
    localparam int CPU_DW = 8;

    typedef struct packed {
        logic [CPU_AW-1:0] addr;
        logic [CPU_DW-1:0] data;
    } cpu_wr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2,
        WAIT   = 2'd3
    } wr_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock first-word-fall-through FIFO. dout shows the head entry
//   whenever empty=0. A push while full is accepted only if a pop happens in
//   the same cycle; a pop while empty is ignored.
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   push, din    write request and data
//   pop          consume head (ignored when empty)
//   dout         head entry
//   full, empty  occupancy flags
//   count        number of stored entries (0..DEPTH)
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 23
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == (AW+1)'(DEPTH));
        pop_ok  = pop & ~empty;
        push_ok = push & (~full | pop_ok);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        dout  = mem_q[rd_ptr_q];
        count = count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head outputs read zero when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/cpu_write_capture.sv
// cpu_write_capture
//   Samples the asynchronous cartridge CPU bus on clk, detects completed CPU
//   writes to $8000-$FFFF and queues them as addr/data beats for the mapper
//   register decode.
// Ports
//   clk, rst                  capture clock, asynchronous active-high reset
//   m2, romsel, cpu_rw_in     async CPU bus controls (romsel active low, rw 0=write)
//   cpu_addr_in, cpu_data_in  async CPU A14..A0 and D7..D0
//   wr_valid/wr_ready         downstream handshake for the head beat
//   wr_addr, wr_data          head beat contents (valid while wr_valid)
//   overflow                  sticky: a write was dropped on a full queue
//
// state  | meaning
// IDLE   | bus idle, waiting for a qualified write cycle to start
// ARMED  | qualified write in progress, counting m2-high clocks, tracking bus
// COMMIT | m2 fell after a long enough high phase, push shadow into queue
// WAIT   | hold off until m2 low and romsel high (also the post-reset state)
module cpu_write_capture
    import mapper_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HIGH    = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m2,
    input  logic              romsel,
    input  logic              cpu_rw_in,
    input  logic [CPU_AW-1:0] cpu_addr_in,
    input  logic [CPU_DW-1:0] cpu_data_in,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [CPU_AW-1:0] wr_addr,
    output logic [CPU_DW-1:0] wr_data,
    output logic              overflow
);

    localparam int HW = $clog2(MIN_HIGH + 1);
    localparam int SW = $clog2(SYNC_STAGES + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [SYNC_STAGES-1:0] m2_sync_q, m2_sync_d;
    logic [SYNC_STAGES-1:0] romsel_sync_q, romsel_sync_d;
    logic [SYNC_STAGES-1:0] rw_sync_q, rw_sync_d;
    cpu_wr_t                bus_q, bus_d;
    cpu_wr_t                shadow_q, shadow_d;
    wr_state_e              state_q, state_d;
    logic [HW-1:0]          hcnt_q, hcnt_d;
    logic [SW-1:0]          settle_q, settle_d;
    logic                   overflow_q, overflow_d;

    logic    m2_s, romsel_s, rw_s, qual;
    logic    fifo_push, fifo_full, fifo_empty;
    cpu_wr_t fifo_dout;
    logic [CW-1:0] unused_fifo_count;

    always_comb begin
        m2_sync_d     = {m2_sync_q[SYNC_STAGES-2:0], m2};
        romsel_sync_d = {romsel_sync_q[SYNC_STAGES-2:0], romsel};
        rw_sync_d     = {rw_sync_q[SYNC_STAGES-2:0], cpu_rw_in};
        m2_s     = m2_sync_q[SYNC_STAGES-1];
        romsel_s = romsel_sync_q[SYNC_STAGES-1];
        rw_s     = rw_sync_q[SYNC_STAGES-1];
        qual     = m2_s & ~romsel_s & ~rw_s;

        bus_d.addr = cpu_addr_in;
        bus_d.data = cpu_data_in;

        // Reset leaves the synchronisers showing an idle bus; this down-counter
        // keeps WAIT closed until the chain carries real samples, so a write
        // already in progress at reset release is never mistaken for a fresh one.
        settle_d = (settle_q != '0) ? settle_q - SW'(1) : settle_q;

        state_d  = state_q;
        hcnt_d   = hcnt_q;
        shadow_d = shadow_q;
        case (state_q)
            IDLE: begin
                if (qual) begin
                    state_d  = ARMED;
                    hcnt_d   = HW'(1);
                    shadow_d = bus_q;
                end
            end
            ARMED: begin
                if (!m2_s) begin
                    state_d = (hcnt_q >= HW'(MIN_HIGH)) ? COMMIT : IDLE;
                end else if (!qual) begin
                    state_d = IDLE;
                end else begin
                    if (hcnt_q != HW'(MIN_HIGH)) hcnt_d = hcnt_q + HW'(1);
                    shadow_d = bus_q;
                end
            end
            COMMIT: state_d = WAIT;
            WAIT: begin
                if (!m2_s && romsel_s && settle_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        fifo_push = (state_q == COMMIT);
        // Full implies non-empty, so wr_ready alone says whether a pop frees a slot.
        overflow_d = overflow_q | (fifo_push & fifo_full & ~wr_ready);

        wr_valid = ~fifo_empty;
        wr_addr  = fifo_dout.addr;
        wr_data  = fifo_dout.data;
        overflow = overflow_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m2_sync_q     <= '0;
            romsel_sync_q <= '1;
            rw_sync_q     <= '1;
            bus_q         <= '0;
            shadow_q      <= '0;
            state_q       <= WAIT;
            hcnt_q        <= '0;
            settle_q      <= SW'(SYNC_STAGES);
            overflow_q    <= 1'b0;
        end else begin
            m2_sync_q     <= m2_sync_d;
            romsel_sync_q <= romsel_sync_d;
            rw_sync_q     <= rw_sync_d;
            bus_q         <= bus_d;
            shadow_q      <= shadow_d;
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            settle_q      <= settle_d;
            overflow_q    <= overflow_d;
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(cpu_wr_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (shadow_q),
        .pop   (wr_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

endmodule
